control_unit: RTL and testbench

Multi-cycle controller for the mini CPU. It sequences fetch and execute and drives every control and enable input of the bus-based datapath. It consumes the datapath's IR contents and branch-condition flag, and has no datapath registers of its own. It sits directly upstream of the datapath: every bus driver, register enable and memory strobe originates here.

---
 rtl/control_unit.sv | 156 +++++++++++++++
 tb/tb_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle Moore controller for the mini CPU: fetch F0-F2, execute T3-T7, HALT.
// Define CU_MULDIV_EN to build the mul/div sequences; otherwise mul/div run as nop.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        run,
  output logic        IRin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout,
  output logic        PCin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, IncPC,
  output logic        Read, Write
);
  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                         OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                         OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                         OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                         OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001,
                         OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100,
                         OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111,
                         OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

  typedef enum logic [3:0] {S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT} state_t;

  state_t     state, state_nxt;
  logic [4:0] opc;
  logic [2:0] step, len;
  logic       zin;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_RST;
      opc   <= 5'd0;
    end else begin
      state <= state_nxt;
      if (state == S_F2) opc <= ir[31:27];
    end
  end

  // Execute length per opcode; anything unlisted (nop, jr, in, out, mf*, halt, undefined) is one step.
  always_comb begin
    len = 3'd1;
    case (opc)
      OP_NEG, OP_NOT, OP_JAL: len = 3'd2;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: len = 3'd3;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV: len = 3'd4;
`endif
      OP_ST, OP_BR: len = 3'd4;
      OP_LD: len = 3'd5;
      default: len = 3'd1;
    endcase
  end

  always_comb begin
    case (state)
      S_T3:    step = 3'd1;
      S_T4:    step = 3'd2;
      S_T5:    step = 3'd3;
      S_T6:    step = 3'd4;
      S_T7:    step = 3'd5;
      default: step = 3'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_F0;
      S_F0:  state_nxt = S_F1;
      S_F1:  state_nxt = S_F2;
      S_F2:  state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7:
        if (step == len) state_nxt = (opc == OP_HALT || stop) ? S_HALT : S_F0;
        else             state_nxt = state_t'(state + 4'd1);
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

  assign run     = (state != S_RST) && (state != S_HALT);
  assign Zhighin = zin;
  assign Zlowin  = zin;

  always_comb begin
    IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; Cout = 1'b0; PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0;
    Zlowout = 1'b0; HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; PCin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    OutPortin = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0; zin = 1'b0;
    case (state)
      S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; zin = 1'b1; end
      S_F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
          begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        OP_NEG, OP_NOT: begin Grb = 1'b1; Rout = 1'b1; zin = 1'b1; end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST:
          begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
        OP_BR:   begin Gra = 1'b1; Rout = 1'b1; end
        OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
        OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
        OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        default: ;
      endcase
      S_T4: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
          begin Grc = 1'b1; Rout = 1'b1; zin = 1'b1; end
        OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin Cout = 1'b1; zin = 1'b1; end
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV: begin Grb = 1'b1; Rout = 1'b1; zin = 1'b1; end
`endif
        OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
        OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        default: ;
      endcase
      S_T5: case (opc)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
        OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV: begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
        OP_BR: begin Cout = 1'b1; zin = 1'b1; end
        default: ;
      endcase
      S_T6: case (opc)
        OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
        OP_ST: begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
`ifdef CU_MULDIV_EN
        OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
        // Branch target is already in Z; only the PC load depends on the live condition.
        OP_BR: begin Zlowout = 1'b1; PCin = con; end
        default: ;
      endcase
      S_T7: if (opc == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle control words checked against hand-built tables.
module tb_control_unit;
  logic        clock = 1'b0, clear = 1'b1, con = 1'b0, stop = 1'b0;
  logic [31:0] ir = 32'h0;
  logic run, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout, Zhighout, Zlowout;
  logic HIout, LOout, InPortout, PCin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin;
  logic OutPortin, IncPC, Read, Write;
  logic [27:0] ctl;
  int errors = 0, checks = 0;

  localparam logic [27:0] M_RUN = 28'd1 << 27, M_IRIN = 28'd1 << 26, M_GRA = 28'd1 << 25,
    M_GRB = 28'd1 << 24, M_GRC = 28'd1 << 23, M_RIN = 28'd1 << 22, M_ROUT = 28'd1 << 21,
    M_BAOUT = 28'd1 << 20, M_COUT = 28'd1 << 19, M_PCOUT = 28'd1 << 18, M_MDROUT = 28'd1 << 17,
    M_ZHOUT = 28'd1 << 16, M_ZLOUT = 28'd1 << 15, M_HIOUT = 28'd1 << 14, M_LOOUT = 28'd1 << 13,
    M_INPOUT = 28'd1 << 12, M_PCIN = 28'd1 << 11, M_MARIN = 28'd1 << 10, M_MDRIN = 28'd1 << 9,
    M_YIN = 28'd1 << 8, M_ZHIN = 28'd1 << 7, M_ZLIN = 28'd1 << 6, M_HIIN = 28'd1 << 5,
    M_LOIN = 28'd1 << 4, M_OUTPIN = 28'd1 << 3, M_INCPC = 28'd1 << 2, M_READ = 28'd1 << 1,
    M_WRITE = 28'd1;
  localparam logic [27:0] M_ZIN = M_ZHIN | M_ZLIN;
  localparam logic [27:0] E_F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [27:0] E_F1 = M_RUN | M_ZLOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [27:0] E_F2 = M_RUN | M_MDROUT | M_IRIN;

  assign ctl = {run, IRin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout, Zhighout,
                Zlowout, HIout, LOout, InPortout, PCin, MARin, MDRin, Yin, Zhighin, Zlowin,
                HIin, LOin, OutPortin, IncPC, Read, Write};

  control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .stop(stop), .run(run), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in RST with clear low; the next tick lands in F0.
  task automatic do_reset;
    clear = 1'b1; stop = 1'b0; con = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (ctl !== 28'd0) begin errors++; $display("FAIL reset_rst got=%h exp=%h", ctl, 28'd0); end
    ir = 32'h1800_0000;
    repeat (5) tick();
    checks++;
    if (ctl !== (M_RUN | M_GRC | M_ROUT | M_ZIN)) begin
      errors++; $display("FAIL reset_pre_t4 got=%h exp=%h", ctl, M_RUN | M_GRC | M_ROUT | M_ZIN);
    end
    #1 clear = 1'b1;
    #1;
    checks++;
    if (ctl !== 28'd0) begin errors++; $display("FAIL reset_async got=%h exp=%h", ctl, 28'd0); end
    tick();
    checks++;
    if (ctl !== 28'd0) begin errors++; $display("FAIL reset_held got=%h exp=%h", ctl, 28'd0); end
    clear = 1'b0;
    tick();
    checks++;
    if (ctl !== E_F0) begin errors++; $display("FAIL reset_release_f0 got=%h exp=%h", ctl, E_F0); end
  endtask

  task automatic test_add;
    logic [27:0] e[$];
    do_reset();
    ir = 32'h1800_0000;
    e = {E_F0, E_F1, E_F2, M_RUN | M_GRB | M_ROUT | M_YIN, M_RUN | M_GRC | M_ROUT | M_ZIN,
         M_RUN | M_ZLOUT | M_GRA | M_RIN, E_F0};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL add step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
  endtask

  task automatic test_ld;
    logic [27:0] e[$];
    do_reset();
    ir = 32'h0000_0000;
    e = {E_F0, E_F1, E_F2, M_RUN | M_GRB | M_BAOUT | M_YIN, M_RUN | M_COUT | M_ZIN,
         M_RUN | M_ZLOUT | M_MARIN, M_RUN | M_READ | M_MDRIN, M_RUN | M_MDROUT | M_GRA | M_RIN,
         E_F0};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL ld step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
  endtask

  // con is held at the opposite value outside T6 so only the T6 sample matters.
  task automatic test_br(input logic c);
    logic [27:0] e[$];
    do_reset();
    ir = 32'h9800_0000;
    e = {E_F0, E_F1, E_F2, M_RUN | M_GRA | M_ROUT, M_RUN | M_PCOUT | M_YIN,
         M_RUN | M_COUT | M_ZIN, M_RUN | M_ZLOUT | (c ? M_PCIN : 28'd0), E_F0};
    for (int i = 0; i < e.size(); i++) begin
      con = (i == 6) ? c : ~c;
      tick(); checks++;
      if (ctl !== e[i]) begin
        errors++; $display("FAIL br con=%0b step %0d got=%h exp=%h", c, i, ctl, e[i]);
      end
    end
    con = 1'b0;
  endtask

  task automatic test_jal;
    logic [27:0] e[$];
    do_reset();
    ir = 32'hA800_0000;
    e = {E_F0, E_F1, E_F2, M_RUN | M_PCOUT | M_GRB | M_RIN, M_RUN | M_GRA | M_ROUT | M_PCIN, E_F0};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL jal step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
  endtask

  task automatic test_halt;
    logic [27:0] e[$];
    int bad;
    do_reset();
    ir = 32'hD800_0000;
    e = {E_F0, E_F1, E_F2, M_RUN};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL halt step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
    bad = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ctl !== 28'd0 && bad < 0) bad = i;
    end
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL halt_absorb first bad cycle=%0d exp=0", bad); end
  endtask

  task automatic test_stop;
    logic [27:0] e[$];
    do_reset();
    ir = 32'h1800_0000;
    stop = 1'b1;
    e = {E_F0, E_F1, E_F2, M_RUN | M_GRB | M_ROUT | M_YIN, M_RUN | M_GRC | M_ROUT | M_ZIN,
         M_RUN | M_ZLOUT | M_GRA | M_RIN, 28'd0, 28'd0};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL stop step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
    stop = 1'b0;
  endtask

  task automatic test_nop(input logic [31:0] instr);
    logic [27:0] e[$];
    do_reset();
    ir = instr;
    e = {E_F0, E_F1, E_F2, M_RUN, E_F0, E_F1};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin
        errors++; $display("FAIL nop ir=%h step %0d got=%h exp=%h", instr, i, ctl, e[i]);
      end
    end
  endtask

`ifdef CU_MULDIV_EN
  task automatic test_mul;
    logic [27:0] e[$];
    do_reset();
    ir = 32'h7800_0000;
    e = {E_F0, E_F1, E_F2, M_RUN | M_GRA | M_ROUT | M_YIN, M_RUN | M_GRB | M_ROUT | M_ZIN,
         M_RUN | M_ZLOUT | M_LOIN, M_RUN | M_ZHOUT | M_HIIN, E_F0};
    for (int i = 0; i < e.size(); i++) begin
      tick(); checks++;
      if (ctl !== e[i]) begin errors++; $display("FAIL mul step %0d got=%h exp=%h", i, ctl, e[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_br(1'b0);
    test_br(1'b1);
    test_jal();
    test_halt();
    test_stop();
    test_nop(32'hF000_0000);
    test_nop(32'hD000_0000);
`ifdef CU_MULDIV_EN
    test_mul();
`else
    test_nop(32'h7800_0000);
    test_nop(32'h8000_0000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
